// File: rtl/vram_host_port_if.sv
// vram_host_port_if: host write bus from the SBC glue into the VRAM port
interface vram_host_port_if #(parameter int AW = 13, parameter int DW = 16);
  logic          host_wr_valid;
  logic          host_wr_ready;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [1:0]    host_be;
  modport master (output host_wr_valid, host_addr, host_wdata, host_be, input host_wr_ready);
  modport slave  (input host_wr_valid, host_addr, host_wdata, host_be, output host_wr_ready);
endinterface

// File: rtl/vram_host_port.sv
// vram_host_port: shares one SRAM between display fetches (priority) and buffered host writes
module vram_host_port #(
  parameter int FIFO_DEPTH = 8,
  parameter int AW = 13,
  parameter int DW = 16,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int LW = PW + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  vram_host_port_if.slave      host,
  input  logic [AW-1:0]        disp_addr,
  input  logic                 disp_oe,
  input  logic                 disp_rw,
  output logic [DW-1:0]        disp_data,
  output logic [LW-1:0]        fifo_level,
  output logic                 collision,
  input  logic                 clr_collision,
  output logic [AW-1:0]        sram_addr,
  output logic [DW-1:0]        sram_dq_o,
  output logic                 sram_dq_oe,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic                 sram_ub_n,
  output logic                 sram_lb_n,
  input  logic [DW-1:0]        sram_dq_i
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    be;
  } entry_t;
  state_t        state_q, state_d;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        mem_d [FIFO_DEPTH];
  entry_t        head;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          collision_q, collision_d;
  logic          fetch, empty, full, push, pop, drive;
  assign disp_data          = sram_dq_i;
  assign fifo_level         = cnt_q;
  assign collision          = collision_q;
  assign host.host_wr_ready = ready_q & ~full;
  // write FIFO bookkeeping; zero-enable entries are discarded from IDLE without an SRAM cycle
  always_comb begin
    fetch = disp_oe & disp_rw;
    head  = mem_q[rp_q];
    empty = cnt_q == '0;
    full  = cnt_q == LW'(FIFO_DEPTH);
    push  = host.host_wr_valid & host.host_wr_ready;
    pop   = (state_q == STROBE) | (state_q == IDLE & ~empty & head.be == 2'b00);
    mem_d = mem_q;
    if (push) mem_d[wp_q] = '{addr: host.host_addr, data: host.host_wdata, be: host.host_be};
    wp_d    = wp_q + PW'(push);
    rp_d    = rp_q + PW'(pop);
    cnt_d   = cnt_q + LW'(push) - LW'(pop);
    ready_d = 1'b1;
  end
  // write FSM and pin mux; a fetch owns the pins except during STROBE, where the write completes
  always_comb begin
    state_d     = state_q == IDLE  ? ((~empty & head.be != 2'b00 & ~fetch) ? SETUP : IDLE) :
                  state_q == SETUP ? (fetch ? IDLE : STROBE) : IDLE;
    drive       = state_q == STROBE | (state_q == SETUP & ~fetch);
    sram_addr   = drive ? head.addr : fetch ? disp_addr : '0;
    sram_dq_o   = drive ? head.data : '0;
    sram_dq_oe  = drive;
    sram_we_n   = state_q != STROBE;
    sram_oe_n   = ~(fetch & ~drive);
    sram_ub_n   = drive ? ~head.be[1] : ~fetch;
    sram_lb_n   = drive ? ~head.be[0] : ~fetch;
    collision_d = (fetch & state_q == STROBE) | (collision_q & ~clr_collision);
  end
  // state registers; reset drops the FIFO contents and returns the pins to idle at once
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      collision_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      collision_q <= collision_d;
      mem_q       <= mem_d;
    end
  end
endmodule

// File: tb/tb_vram_host_port.sv
// tb_vram_host_port: scoreboard bench with an SRAM model for the VRAM host port
module tb_vram_host_port;
  localparam int AW = 13, DW = 16, DEPTH = 8;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    be;
  } wr_t;
  logic          clk = 1'b0, rstn = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_oe = 1'b0, disp_rw = 1'b1, clr_collision = 1'b0;
  logic [DW-1:0] disp_data, sram_dq_o, sram_dq_i;
  logic [3:0]    fifo_level;
  logic [AW-1:0] sram_addr;
  logic          collision, sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [DW-1:0] mem [1<<AW];
  wr_t           sb [$];
  int            n_checks = 0, n_errors = 0, wr_cnt = 0;
  vram_host_port_if #(.AW(AW), .DW(DW)) host ();
  vram_host_port #(.FIFO_DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .host(host),
    .disp_addr(disp_addr), .disp_oe(disp_oe), .disp_rw(disp_rw), .disp_data(disp_data),
    .fifo_level(fifo_level), .collision(collision), .clr_collision(clr_collision),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n), .sram_dq_i(sram_dq_i)
  );
  always #5 clk = ~clk;
  assign sram_dq_i = mem[sram_addr];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // SRAM model: byte-lane writes on the clock edge that ends a strobe cycle
  always @(posedge clk) begin
    if (rstn && !sram_we_n) begin
      if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq_o[15:8];
      if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dq_o[7:0];
    end
  end
  // every strobe seen on the pins must match the oldest outstanding host write
  always @(negedge clk) begin
    wr_t e;
    if (rstn && !sram_we_n) begin
      wr_cnt++;
      if (sb.size() == 0) check("wr_spurious", 1, 0);
      else begin
        e = sb.pop_front();
        check("wr_addr", 32'(sram_addr), 32'(e.addr));
        check("wr_data", 32'(sram_dq_o), 32'(e.data));
        check("wr_be", {30'd0, ~sram_ub_n, ~sram_lb_n}, 32'(e.be));
      end
    end
  end
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
    int t = 0;
    host.host_wr_valid = 1'b1;
    host.host_addr     = a;
    host.host_wdata    = d;
    host.host_be       = be;
    while (!host.host_wr_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 100) check("push_ready", 32'(host.host_wr_ready), 1);
    if (be != 2'b00) sb.push_back('{a, d, be});
    @(posedge clk); #1;
    host.host_wr_valid = 1'b0;
  endtask
  task automatic wait_empty(input string tag);
    int t = 0;
    while (fifo_level != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check(tag, 32'(fifo_level), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int w0, c, t;
    host.host_wr_valid = 1'b0;
    host.host_addr     = '0;
    host.host_wdata    = '0;
    host.host_be       = '0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    #2;
    check("rst_pins", {27'd0, sram_we_n, sram_oe_n, sram_dq_oe, sram_ub_n, sram_lb_n}, 32'b11011);
    check("rst_addr", 32'(sram_addr), 0);
    check("rst_ready", 32'(host.host_wr_ready), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_collision", 32'(collision), 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(host.host_wr_ready), 1);
    w0 = wr_cnt;
    for (int i = 0; i < 3; i++) push(AW'(13'h10 + i), DW'(16'hA5A5 + i), 2'b11);
    check("t1_level3", 32'(fifo_level), 3);
    wait_empty("t1_drain");
    for (int i = 0; i < 3; i++) check("t1_mem", 32'(mem[13'h10 + i]), 32'(16'hA5A5 + i));
    check("t1_wr_cnt", wr_cnt - w0, 3);
    disp_oe = 1'b1;
    disp_addr = 13'h10;
    w0 = wr_cnt;
    for (int i = 0; i < DEPTH; i++) push(AW'(13'h100 + i), DW'(16'h1000 + i), 2'b11);
    check("t2_level_full", 32'(fifo_level), DEPTH);
    check("t2_ready_full", 32'(host.host_wr_ready), 0);
    check("t2_no_write", wr_cnt - w0, 0);
    check("t2_fetch_data", 32'(disp_data), 32'h A5A5);
    check("t2_fetch_oe_n", 32'(sram_oe_n), 0);
    disp_oe = 1'b0;
    c = 0;
    while (fifo_level != 0 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check("t2_drain_cycles", c, 24);
    check("t2_wr_cnt", wr_cnt - w0, DEPTH);
    check("t2_mem_last", 32'(mem[13'h107]), 32'h1007);
    disp_oe = 1'b1;
    disp_rw = 1'b0;
    #1;
    check("rw0_ignored", 32'(sram_oe_n), 1);
    disp_oe = 1'b0;
    disp_rw = 1'b1;
    push(13'h20, 16'hBEEF, 2'b11);
    @(posedge clk); #1;
    check("t3_in_setup", {30'd0, sram_dq_oe, sram_we_n}, 32'b11);
    disp_oe = 1'b1;
    disp_addr = 13'h11;
    #1;
    check("t3_fetch_data", 32'(disp_data), 32'hA5A6);
    check("t3_fetch_pins", {30'd0, sram_dq_oe, sram_oe_n}, 0);
    check("t3_fetch_addr", 32'(sram_addr), 32'h11);
    @(posedge clk); #1;
    disp_oe = 1'b0;
    check("t3_abort_level", 32'(fifo_level), 1);
    wait_empty("t3_drain");
    check("t3_mem", 32'(mem[13'h20]), 32'hBEEF);
    check("t3_collision", 32'(collision), 0);
    push(13'h30, 16'hCAFE, 2'b11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t4_in_strobe", 32'(sram_we_n), 0);
    disp_oe = 1'b1;
    disp_addr = 13'h10;
    #1;
    check("t4_strobe_addr", 32'(sram_addr), 32'h30);
    check("t4_strobe_pins", {30'd0, sram_we_n, sram_oe_n}, 32'b01);
    @(posedge clk); #1;
    disp_oe = 1'b0;
    check("t4_collision_set", 32'(collision), 1);
    check("t4_mem", 32'(mem[13'h30]), 32'hCAFE);
    clr_collision = 1'b1;
    @(posedge clk); #1;
    clr_collision = 1'b0;
    check("t4_collision_clr", 32'(collision), 0);
    mem[13'h1FFF] = 16'hFFFF;
    push(13'h1FFF, 16'h1234, 2'b01);
    wait_empty("t5_drain");
    check("t5_lower_byte", 32'(mem[13'h1FFF]), 32'hFF34);
    w0 = wr_cnt;
    push(13'h40, 16'h5555, 2'b00);
    wait_empty("t5_be0_drain");
    repeat (3) @(posedge clk);
    #1;
    check("t5_be0_no_write", wr_cnt - w0, 0);
    check("t5_be0_mem", 32'(mem[13'h40]), 0);
    check("sb_empty", sb.size(), 0);
    push(13'h50, 16'h5050, 2'b11);
    push(13'h60, 16'h6060, 2'b11);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (sram_we_n && t < 20);
    check("t6_strobe_seen", 32'(sram_we_n), 0);
    #2 rstn = 1'b0;
    #1;
    check("t6_async_pins", {30'd0, sram_we_n, sram_dq_oe}, 32'b10);
    check("t6_ready_in_rst", 32'(host.host_wr_ready), 0);
    sb.delete();
    w0 = wr_cnt;
    #10 rstn = 1'b1;
    @(posedge clk); #1;
    check("t6_level", 32'(fifo_level), 0);
    check("t6_ready", 32'(host.host_wr_ready), 1);
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_write", wr_cnt - w0, 0);
    check("t6_mem_lost", 32'(mem[13'h60]), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
